// File: rtl/pe_tile_reducer_pkg.sv
// rtl/pe_tile_reducer_pkg.sv - shared widths and requantization helpers for the tile reducer
package pe_tile_reducer_pkg;

    localparam int PROD_W_DEF = 32;
    localparam int ACC_W_DEF  = 40;
    localparam int OUT_W_DEF  = 16;

    // Wide enough to hold accumulator + bias + rounding constant without overflow
    typedef logic signed [63:0] wide_t;

    function automatic wide_t sat_max(input int w);
        return (wide_t'(1) <<< (w - 1)) - wide_t'(1);
    endfunction

    function automatic wide_t sat_min(input int w);
        return -(wide_t'(1) <<< (w - 1));
    endfunction

    // Round half toward +inf, then arithmetic shift; a zero shift passes through untouched
    function automatic wide_t round_shift(input wide_t r, input int sh);
        if (sh == 0) begin
            return r;
        end
        return (r + (wide_t'(1) <<< (sh - 1))) >>> sh;
    endfunction

endpackage

// File: rtl/pe_tile_reducer_tile_adder_tree.sv
// rtl/pe_tile_reducer_tile_adder_tree.sv - nine products to a registered tile sum in two stages
module tile_adder_tree
    import pe_tile_reducer_pkg::*;
#(
    parameter int PROD_W = PROD_W_DEF,
    parameter int SIDE_W = 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     en,
    input  logic                     in_valid,
    input  logic [9*PROD_W-1:0]      prods,
    input  logic [SIDE_W-1:0]        in_side,
    output logic                     tile_valid,
    output logic signed [PROD_W+3:0] tile,
    output logic [SIDE_W-1:0]        tile_side
);

    logic signed [PROD_W+1:0] ext [9];
    logic signed [PROD_W+1:0] row_c [3];
    logic signed [PROD_W+1:0] row_q [3];
    logic signed [PROD_W+3:0] row_ext [3];
    logic                     s1_valid;
    logic [SIDE_W-1:0]        s1_side;

    always_comb begin
        for (int i = 0; i < 9; i++) begin
            ext[i] = {{2{prods[i*PROD_W+PROD_W-1]}}, prods[i*PROD_W +: PROD_W]};
        end
        for (int r = 0; r < 3; r++) begin
            row_c[r]   = ext[3*r] + ext[3*r+1] + ext[3*r+2];
            row_ext[r] = {{2{row_q[r][PROD_W+1]}}, row_q[r]};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid   <= 1'b0;
            s1_side    <= '0;
            tile_valid <= 1'b0;
            tile_side  <= '0;
            tile       <= '0;
            for (int r = 0; r < 3; r++) begin
                row_q[r] <= '0;
            end
        end else if (en) begin
            s1_valid   <= in_valid;
            s1_side    <= in_side;
            tile_valid <= s1_valid;
            tile_side  <= s1_side;
            tile       <= row_ext[0] + row_ext[1] + row_ext[2];
            for (int r = 0; r < 3; r++) begin
                row_q[r] <= row_c[r];
            end
        end
    end

endmodule

// File: rtl/pe_tile_reducer.sv
// rtl/pe_tile_reducer.sv - accumulates 3x3 tile sums across channels, then bias, requantize, ReLU, saturate
module pe_tile_reducer
    import pe_tile_reducer_pkg::*;
#(
    parameter int PROD_W  = PROD_W_DEF,
    parameter int ACC_W   = ACC_W_DEF,
    parameter int OUT_W   = OUT_W_DEF,
    parameter int SHIFT   = 8,
    parameter int RELU_EN = 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic                     in_first,
    input  logic                     in_last,
    input  logic [PROD_W-1:0]        prod_00,
    input  logic [PROD_W-1:0]        prod_01,
    input  logic [PROD_W-1:0]        prod_02,
    input  logic [PROD_W-1:0]        prod_10,
    input  logic [PROD_W-1:0]        prod_11,
    input  logic [PROD_W-1:0]        prod_12,
    input  logic [PROD_W-1:0]        prod_20,
    input  logic [PROD_W-1:0]        prod_21,
    input  logic [PROD_W-1:0]        prod_22,
    input  logic [PROD_W-1:0]        bias,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic signed [OUT_W-1:0]  out_pixel,
    output logic                     out_sat
);

    localparam int    SIDE_W = PROD_W + 2;
    localparam wide_t SAT_HI = sat_max(OUT_W);
    localparam wide_t SAT_LO = sat_min(OUT_W);

    logic                     adv;
    logic                     s2_valid;
    logic signed [PROD_W+3:0] s2_tile;
    logic [SIDE_W-1:0]        s2_side;
    logic                     s2_first;
    logic                     s2_last;
    logic [PROD_W-1:0]        s2_bias;
    logic signed [ACC_W-1:0]  acc;
    logic signed [ACC_W-1:0]  tile_acc;
    logic signed [ACC_W-1:0]  base;
    logic signed [ACC_W-1:0]  sum;
    wide_t                    sum_w;
    wide_t                    bias_w;
    wide_t                    r_w;
    wide_t                    relu_w;
    logic signed [OUT_W-1:0]  pix_next;
    logic                     sat_next;

    // A stalled result freezes the whole pipe, so the input side sees the same stall
    assign adv      = !(out_valid && !out_ready);
    assign in_ready = adv;

    tile_adder_tree #(
        .PROD_W (PROD_W),
        .SIDE_W (SIDE_W)
    ) u_tree (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (adv),
        .in_valid   (in_valid && adv),
        .prods      ({prod_22, prod_21, prod_20, prod_12, prod_11, prod_10, prod_02, prod_01, prod_00}),
        .in_side    ({in_first, in_last, bias}),
        .tile_valid (s2_valid),
        .tile       (s2_tile),
        .tile_side  (s2_side)
    );

    assign s2_first = s2_side[PROD_W+1];
    assign s2_last  = s2_side[PROD_W];
    assign s2_bias  = s2_side[PROD_W-1:0];

    always_comb begin
        tile_acc = {{(ACC_W-PROD_W-4){s2_tile[PROD_W+3]}}, s2_tile};
        base     = s2_first ? '0 : acc;
        sum      = base + tile_acc;
        sum_w    = {{(64-ACC_W){sum[ACC_W-1]}}, sum};
        bias_w   = {{(64-PROD_W){s2_bias[PROD_W-1]}}, s2_bias};
        r_w      = round_shift(sum_w + bias_w, SHIFT);
        relu_w   = r_w;
        if (RELU_EN != 0 && r_w < 0) begin
            relu_w = '0;
        end
        // ReLU zeroing lands inside the range, so only the clamp can raise sat
        pix_next = OUT_W'(relu_w);
        sat_next = 1'b0;
        if (relu_w > SAT_HI) begin
            pix_next = OUT_W'(SAT_HI);
            sat_next = 1'b1;
        end else if (relu_w < SAT_LO) begin
            pix_next = OUT_W'(SAT_LO);
            sat_next = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc       <= '0;
            out_valid <= 1'b0;
            out_pixel <= '0;
            out_sat   <= 1'b0;
        end else if (adv) begin
            if (s2_valid && s2_last) begin
                out_pixel <= pix_next;
                out_sat   <= sat_next;
                out_valid <= 1'b1;
                acc       <= '0;
            end else begin
                out_valid <= 1'b0;
                if (s2_valid) begin
                    acc <= sum;
                end
            end
        end
    end

endmodule

// File: tb/tb_pe_tile_reducer.sv
// tb/tb_pe_tile_reducer.sv - randomized and directed checks of pe_tile_reducer against a reference model
module tb_pe_tile_reducer;

    localparam int SHIFT = 8;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid, in_first, in_last, out_ready;
    logic [31:0] p [9];
    logic [31:0] bias;
    logic        in_ready, out_valid, out_sat;
    logic [15:0] out_pixel;
    logic        in_ready_nr, out_valid_nr, out_sat_nr;
    logic [15:0] out_pixel_nr;

    always #5 clk = ~clk;

    pe_tile_reducer #(.RELU_EN(1)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_first(in_first), .in_last(in_last),
        .prod_00(p[0]), .prod_01(p[1]), .prod_02(p[2]),
        .prod_10(p[3]), .prod_11(p[4]), .prod_12(p[5]),
        .prod_20(p[6]), .prod_21(p[7]), .prod_22(p[8]),
        .bias(bias), .out_valid(out_valid), .out_ready(out_ready),
        .out_pixel(out_pixel), .out_sat(out_sat)
    );

    pe_tile_reducer #(.RELU_EN(0)) dut_nr (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_nr),
        .in_first(in_first), .in_last(in_last),
        .prod_00(p[0]), .prod_01(p[1]), .prod_02(p[2]),
        .prod_10(p[3]), .prod_11(p[4]), .prod_12(p[5]),
        .prod_20(p[6]), .prod_21(p[7]), .prod_22(p[8]),
        .bias(bias), .out_valid(out_valid_nr), .out_ready(out_ready),
        .out_pixel(out_pixel_nr), .out_sat(out_sat_nr)
    );

    typedef struct {
        int pix_r;
        bit sat_r;
        int pix_n;
        bit sat_n;
    } exp_t;

    exp_t    exp_q [$];
    longint  m_acc;
    int      vectors;
    int      miscompares;
    bit      rand_ready_en;

    function automatic void ref_out(input longint s, input longint b, input bit relu,
                                    output int pix, output bit sat);
        longint r;
        r = s + b;
        if (SHIFT > 0) r = (r + (longint'(1) << (SHIFT - 1))) >>> SHIFT;
        if (relu && r < 0) r = 0;
        sat = 1'b0;
        if (r > 32767) begin
            r = 32767;
            sat = 1'b1;
        end else if (r < -32768) begin
            r = -32768;
            sat = 1'b1;
        end
        pix = int'(r);
    endfunction

    function automatic void model_beat(input bit f, input bit l, input logic [31:0] b);
        longint tile, s;
        exp_t e;
        tile = 0;
        for (int i = 0; i < 9; i++) tile += longint'($signed(p[i]));
        s = (f ? 0 : m_acc) + tile;
        if (l) begin
            ref_out(s, longint'($signed(b)), 1'b1, e.pix_r, e.sat_r);
            ref_out(s, longint'($signed(b)), 1'b0, e.pix_n, e.sat_n);
            exp_q.push_back(e);
            m_acc = 0;
        end else begin
            m_acc = s;
        end
    endfunction

    // Scoreboard: every handshake must match the model in order; stalled outputs must hold
    logic        prev_stall;
    logic [15:0] prev_pix;
    logic        prev_sat;
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_stall = 1'b0;
        end else begin
            vectors++;
            if (out_valid !== out_valid_nr || in_ready !== in_ready_nr) begin
                miscompares++;
                $display("FAIL dut_pair_handshake: valid %b/%b ready %b/%b",
                         out_valid, out_valid_nr, in_ready, in_ready_nr);
            end
            if (prev_stall) begin
                vectors++;
                if (out_valid !== 1'b1 || out_pixel !== prev_pix || out_sat !== prev_sat) begin
                    miscompares++;
                    $display("FAIL stall_hold: got valid=%b pix=%0d sat=%b, need 1 %0d %b",
                             out_valid, $signed(out_pixel), out_sat, $signed(prev_pix), prev_sat);
                end
            end
            if (out_valid && out_ready) begin
                vectors++;
                if (exp_q.size() == 0) begin
                    miscompares++;
                    $display("FAIL unexpected_output: got pix=%0d with nothing expected",
                             $signed(out_pixel));
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    if (int'($signed(out_pixel)) !== e.pix_r || out_sat !== e.sat_r ||
                        int'($signed(out_pixel_nr)) !== e.pix_n || out_sat_nr !== e.sat_n) begin
                        miscompares++;
                        $display("FAIL scoreboard: got %0d/%b nr %0d/%b, need %0d/%b nr %0d/%b",
                                 $signed(out_pixel), out_sat, $signed(out_pixel_nr), out_sat_nr,
                                 e.pix_r, e.sat_r, e.pix_n, e.sat_n);
                    end
                end
            end
            prev_stall = out_valid && !out_ready;
            prev_pix   = out_pixel;
            prev_sat   = out_sat;
        end
    end

    always @(posedge clk) begin
        if (rand_ready_en) begin
            #1 out_ready = ($urandom_range(0, 3) != 0);
        end
    end

    task automatic send_beat(input bit f, input bit l, input logic [31:0] b);
        bit acc_ok;
        acc_ok = 1'b0;
        in_first = f;
        in_last  = l;
        bias     = b;
        in_valid = 1'b1;
        for (int n = 0; n < 200 && !acc_ok; n++) begin
            @(negedge clk);
            acc_ok = in_ready;
            @(posedge clk);
            #1;
        end
        if (acc_ok) begin
            model_beat(f, l, b);
        end else begin
            miscompares++;
            $display("FAIL accept_timeout: in_ready stayed 0, need 1 within 200 cycles");
        end
        in_valid = 1'b0;
    endtask

    task automatic wait_out(output bit ok);
        ok = 1'b0;
        for (int n = 0; n < 50 && !ok; n++) begin
            @(negedge clk);
            ok = out_valid;
        end
        if (!ok) begin
            miscompares++;
            $display("FAIL out_timeout: out_valid stayed 0, need 1 within 50 cycles");
        end
    endtask

    task automatic drain();
        for (int n = 0; n < 300 && exp_q.size() != 0; n++) @(negedge clk);
        vectors++;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL lost_outputs: %0d pending, need 0", exp_q.size());
        end
        @(posedge clk);
        #1;
    endtask

    task automatic set_all(input logic [31:0] v);
        for (int i = 0; i < 9; i++) p[i] = v;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        in_valid = 1'b0; in_first = 1'b0; in_last = 1'b0; out_ready = 1'b1;
        bias = '0; set_all('0);
        #12;
        vectors++;
        if (out_valid !== 1'b0 || out_pixel !== 16'd0 || out_sat !== 1'b0 || in_ready !== 1'b1 ||
            out_valid_nr !== 1'b0 || out_pixel_nr !== 16'd0) begin
            miscompares++;
            $display("FAIL reset_state: valid=%b pix=%0d sat=%b ready=%b, need 0 0 0 1",
                     out_valid, out_pixel, out_sat, in_ready);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_single_channel();
        set_all(32'd256);
        send_beat(1'b1, 1'b1, 32'd0);
        for (int c = 1; c <= 3; c++) begin
            @(negedge clk);
            vectors++;
            if (out_valid !== (c == 3)) begin
                miscompares++;
                $display("FAIL latency: cycle T+%0d out_valid=%b, need %b", c, out_valid, c == 3);
            end
        end
        vectors++;
        if ($signed(out_pixel) !== 16'sd9 || out_sat !== 1'b0) begin
            miscompares++;
            $display("FAIL single_channel: got %0d sat %b, need 9 sat 0", $signed(out_pixel), out_sat);
        end
        drain();
    endtask

    task automatic test_three_channels();
        bit ok;
        set_all('0);
        p[4] = 32'd1000;
        send_beat(1'b1, 1'b0, 32'd0);
        send_beat(1'b0, 1'b0, 32'd0);
        send_beat(1'b0, 1'b1, 32'd200);
        wait_out(ok);
        vectors++;
        if ($signed(out_pixel) !== 16'sd13 || out_sat !== 1'b0) begin
            miscompares++;
            $display("FAIL three_channels: got %0d sat %b, need 13 sat 0", $signed(out_pixel), out_sat);
        end
        drain();
    endtask

    task automatic test_relu();
        bit ok;
        set_all('0);
        p[0] = -32'sd5000;
        send_beat(1'b1, 1'b1, 32'd0);
        wait_out(ok);
        vectors++;
        if ($signed(out_pixel) !== 16'sd0 || out_sat !== 1'b0 ||
            $signed(out_pixel_nr) !== -16'sd20 || out_sat_nr !== 1'b0) begin
            miscompares++;
            $display("FAIL relu: got %0d/%b nr %0d/%b, need 0/0 nr -20/0",
                     $signed(out_pixel), out_sat, $signed(out_pixel_nr), out_sat_nr);
        end
        drain();
    endtask

    task automatic test_saturation();
        bit ok;
        set_all(32'h4000_0000);
        send_beat(1'b1, 1'b1, 32'd0);
        wait_out(ok);
        vectors++;
        if ($signed(out_pixel) !== 16'sd32767 || out_sat !== 1'b1 ||
            $signed(out_pixel_nr) !== 16'sd32767 || out_sat_nr !== 1'b1) begin
            miscompares++;
            $display("FAIL sat_pos: got %0d/%b nr %0d/%b, need 32767/1",
                     $signed(out_pixel), out_sat, $signed(out_pixel_nr), out_sat_nr);
        end
        drain();
        set_all(32'hC000_0000);
        send_beat(1'b1, 1'b1, 32'd0);
        wait_out(ok);
        vectors++;
        if ($signed(out_pixel_nr) !== -16'sd32768 || out_sat_nr !== 1'b1 ||
            $signed(out_pixel) !== 16'sd0 || out_sat !== 1'b0) begin
            miscompares++;
            $display("FAIL sat_neg: got nr %0d/%b relu %0d/%b, need nr -32768/1 relu 0/0",
                     $signed(out_pixel_nr), out_sat_nr, $signed(out_pixel), out_sat);
        end
        drain();
    endtask

    task automatic test_back_to_back();
        out_ready = 1'b0;
        fork
            begin
                for (int k = 1; k <= 4; k++) begin
                    set_all('0);
                    p[0] = 32'(256 * k);
                    send_beat(1'b1, 1'b1, 32'd0);
                end
            end
            begin
                bit ok;
                wait_out(ok);
                for (int i = 0; i < 5; i++) begin
                    if (i > 0) @(negedge clk);
                    vectors++;
                    if (in_ready !== 1'b0 || $signed(out_pixel) !== 16'sd1) begin
                        miscompares++;
                        $display("FAIL backpressure_hold: in_ready=%b pix=%0d, need 0 and 1",
                                 in_ready, $signed(out_pixel));
                    end
                end
                @(posedge clk);
                #1 out_ready = 1'b1;
                for (int k = 1; k <= 4; k++) begin
                    int n;
                    n = 0;
                    do begin
                        @(negedge clk);
                        n++;
                    end while (!(out_valid && out_ready) && n < 50);
                    vectors++;
                    if (!(out_valid && out_ready) || $signed(out_pixel) !== 16'(k)) begin
                        miscompares++;
                        $display("FAIL backpressure_order: got %0d (valid %b), need %0d",
                                 $signed(out_pixel), out_valid, k);
                    end
                end
            end
        join
        drain();
    endtask

    task automatic test_reset_mid_pixel();
        bit ok;
        set_all('0);
        p[4] = 32'd1000;
        send_beat(1'b1, 1'b0, 32'd0);
        send_beat(1'b0, 1'b0, 32'd0);
        #3 rst_n = 1'b0;
        m_acc = 0;
        exp_q.delete();
        #1;
        vectors++;
        if (out_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_async: out_valid=%b, need 0", out_valid);
        end
        @(posedge clk);
        #2 rst_n = 1'b1;
        @(posedge clk);
        #1;
        p[4] = 32'd512;
        send_beat(1'b1, 1'b1, 32'd0);
        wait_out(ok);
        vectors++;
        if ($signed(out_pixel) !== 16'sd2) begin
            miscompares++;
            $display("FAIL reset_mid_pixel: got %0d, need 2", $signed(out_pixel));
        end
        drain();
        repeat (6) @(negedge clk);
        @(posedge clk);
        #1;
    endtask

    task automatic test_random();
        bit f, l;
        rand_ready_en = 1'b1;
        for (int i = 0; i < 80; i++) begin
            for (int j = 0; j < 9; j++) p[j] = 32'(int'($urandom_range(0, 32'h80_0000)) - 32'h40_0000);
            f = (i == 0) || ($urandom_range(0, 3) == 0);
            l = (i == 79) || ($urandom_range(0, 2) == 0);
            send_beat(f, l, 32'(int'($urandom_range(0, 32'h2_0000)) - 32'h1_0000));
        end
        rand_ready_en = 1'b0;
        @(posedge clk);
        #2 out_ready = 1'b1;
        drain();
    endtask

    initial begin
        vectors = 0;
        miscompares = 0;
        m_acc = 0;
        rand_ready_en = 1'b0;
        test_reset();
        test_single_channel();
        test_three_channels();
        test_relu();
        test_saturation();
        test_back_to_back();
        test_reset_mid_pixel();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/pe_tile_reducer.md
Name: pe_tile_reducer

Overview:
- Downstream consumer of the 3x3 processing element's nine signed 32-bit partial products; one result per output pixel.
- Sums the nine products of one input channel into a tile sum, then accumulates tile sums across input channels.
- On the last channel it adds the bias, requantizes with a rounding right shift, applies optional ReLU and saturates to output width.
- Sits between the PE array and the output feature-map writer; all transfers use a valid/ready handshake.

Parameters:
PROD_W, 32, width of each signed partial product and of bias
ACC_W, 40, width of the signed channel accumulator
OUT_W, 16, width of the signed output pixel
SHIFT, 8, requantization right shift (0 = no shift, no rounding)
RELU_EN, 1, 1 = clamp negative results to zero before saturation

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  input beat valid
in_ready  out  1  block can accept beat this cycle
in_first  in  1  beat is the first input channel of a pixel
in_last  in  1  beat is the last input channel of a pixel
prod_00..prod_22  in  PROD_W each (9 ports)  signed partial products, row/column indexed
bias  in  PROD_W  signed bias, sampled on the beat with in_last
out_valid  out  1  result valid
out_ready  in  1  downstream accepts result
out_pixel  out  OUT_W  signed requantized result
out_sat  out  1  result was clamped by saturation

Behaviour:
- Reset (asynchronous, rst_n=0): every stage-valid bit = 0; accumulator = 0; out_valid = 0; out_pixel = 0; out_sat = 0.
- Reset mid-pixel discards all in-flight beats and the partial accumulation, with no output.
- Global advance: adv = !(out_valid && !out_ready); in_ready = adv.
  - While adv = 0, all stages, the accumulator and the output registers hold.
  - A beat is accepted when in_valid && in_ready.
- S1, the cycle after accept: three row sums (row r = prod_r0 + prod_r1 + prod_r2), each sign-extended to PROD_W+2. first, last and bias travel with the beat.
- S2: tile sum = sum of the three row sums, PROD_W+4 bits, sign-extended to ACC_W.
- S3 with a valid beat:
  - base = 0 if the beat has first, otherwise the accumulator.
  - sum = base + tile. ACC_W arithmetic wraps on overflow; ACC_W is sized so this does not occur at defaults.
  - Not last: accumulator <= sum; no output.
  - Last: r = sum + sext(bias), then rounding shift r = (r + 2^(SHIFT-1)) >>> SHIFT (round half toward +inf; skipped when SHIFT=0).
  - If RELU_EN and r < 0, r = 0.
  - Clamp r to [-2^(OUT_W-1), 2^(OUT_W-1)-1]. out_sat = 1 only if the clamp changed the value; ReLU zeroing does not set it.
  - out_pixel <= result; out_valid <= 1; accumulator <= 0.
- out_valid clears on a handshake unless a new last beat completes in the same cycle, in which case the register reloads and out_valid stays 1.
- Latency: the result registers 3 cycles after the last beat is accepted (out_valid high in cycle T+3 for an accept in T). Full throughput is one beat per cycle.
- in_first and in_last on the same beat form a single-channel pixel.
- A beat without in_first that follows a completed pixel accumulates onto 0, because the accumulator was cleared.
- An in_first beat arriving mid-pixel restarts the accumulation; the prior partial sum is discarded.
- out_pixel and out_sat hold stable while out_valid && !out_ready.

Decomposition:
- Shared package: PROD_W, ACC_W and OUT_W defaults; saturation min/max constant functions; a round-shift function.
- One natural sub-module, tile_adder_tree: nine products to a registered tile sum over stages S1–S2, with enable = adv and a valid bit passed through.

Test Plan:
- Single channel: all prods = 256, bias = 0, first = last = 1 -> out_pixel = 9, out_sat = 0, out_valid exactly 3 cycles after accept.
- Three channels: prod_11 = 1000, others 0 on each beat; bias = 200 on the last beat -> (3200 + 128) >>> 8 = 13.
- ReLU: prod_00 = -5000, others 0, bias = 0, single channel -> pre-ReLU -20, out_pixel = 0, out_sat = 0. With RELU_EN = 0 -> out_pixel = -20.
- Saturation: all prods = 2^30, single channel -> out_pixel = 32767, out_sat = 1. All prods = -2^30 with RELU_EN = 0 -> -32768, out_sat = 1.
- Backpressure:
  - Stream 4 back-to-back single-channel pixels with values 1..4 (prods = 256·k at prod_00).
  - Hold out_ready = 0 for 5 cycles after the first out_valid. in_ready must drop and out_pixel must stay 1.
  - Release out_ready: outputs 1, 2, 3, 4 appear in order, none lost or duplicated.
- Reset mid-pixel: two non-last beats (prod_11 = 1000), pulse rst_n low asynchronously, then one first+last beat with prod_11 = 512 -> only result (512 + 128) >>> 8 = 2; no stale output.
